// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, false-start rejection, 3-sample majority vote,
// framing/overrun detection and a one-entry output register. Parity state and check are built only with UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SBIT       = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    input  logic            rd,
    output logic [DBIT-1:0] dout,
    output logic            rx_valid,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err,
    output logic            overrun_err
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DBIT);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE - 3);
    localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE - 2);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

    if (DBIT < 5 || DBIT > 9 || OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0 ||
        SBIT < 1 || SBIT > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_param: illegal parameter combination");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state, state_next;
    logic [SW-1:0]   s, s_next;
    logic [NW-1:0]   n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic            v0, v0_next, v1, v1_next;
    logic            fe, fe_next;
    logic            pe, pe_next;
    logic            rx_meta, rxs;
    logic            bit_val, resolve, done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Third vote is the live sample taken on the resolving tick itself.
    assign bit_val = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
    assign resolve = s_tick && (s == S_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
            v0    <= 1'b0;
            v1    <= 1'b0;
            fe    <= 1'b0;
            pe    <= 1'b0;
        end else begin
            state <= state_next;
            s     <= s_next;
            n     <= n_next;
            b     <= b_next;
            v0    <= v0_next;
            v1    <= v1_next;
            fe    <= fe_next;
            pe    <= pe_next;
        end
    end

    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        v0_next    = v0;
        v1_next    = v1;
        fe_next    = fe;
        pe_next    = pe;
        done       = 1'b0;

        if (state != IDLE && state != START && s_tick) begin
            s_next = (s == S_LAST) ? '0 : s + SW'(1);
            if (s == S_V0) v0_next = rxs;
            if (s == S_V1) v1_next = rxs;
        end

        case (state)
            IDLE: begin
                if (!rxs) begin
                    s_next     = '0;
                    state_next = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == S_MID) begin
                        if (!rxs) begin
                            s_next     = '0;
                            n_next     = '0;
                            fe_next    = 1'b0;
                            pe_next    = 1'b0;
                            state_next = DATA;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (resolve) begin
                    b_next = {bit_val, b[DBIT-1:1]};
                    if (n == NW'(DBIT - 1)) begin
                        n_next = '0;
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        n_next = n + NW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (resolve) begin
                    pe_next    = ((^b) ^ bit_val) != 1'(PARITY_ODD);
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (resolve) begin
                    if (n == '0 && !bit_val) fe_next = 1'b1;
                    if (n == NW'(SBIT - 1)) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        n_next = n + NW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout         <= '0;
            rx_valid     <= 1'b0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            overrun_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            rx_done_tick <= done;
            if (done) begin
                dout        <= b;
                frame_err   <= fe_next;
                rx_valid    <= 1'b1;
                overrun_err <= rx_valid && !rd;
`ifdef UART_RX_PARITY_EN
                parity_err  <= pe;
`endif
            end else if (rd && rx_valid) begin
                rx_valid    <= 1'b0;
                overrun_err <= 1'b0;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule
